// File: rtl/tu_seq_pkg.sv
// Shared types and helpers for the test-unit pass sequencer.
package tu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DELAY = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } tu_seq_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_ORDER   = 2'd2
  } tu_err_e;

  // Index width that never collapses to zero for a single unit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tu_seq_timer.sv
// Loadable up-counter; tc flags that the count has reached TERMINAL.
module tu_seq_timer
  import tu_seq_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int TERMINAL = 0
) (
  input  logic clock,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic tc
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign tc = (count_reg == WIDTH'(TERMINAL));

endmodule

// File: rtl/tu_pass_sequencer.sv
// Launches a chain of test units in order, with start delay, per-unit
// timeout and out-of-order pass detection.
module tu_pass_sequencer
  import tu_seq_pkg::*;
#(
  parameter  int NUM_UNITS      = 4,
  parameter  int START_DELAY    = 16,
  parameter  int TIMEOUT_CYCLES = 1000000,
  localparam int UIDX_W         = idx_w(NUM_UNITS)
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 clear,
  input  logic [NUM_UNITS-1:0] unit_pass,
  output logic [NUM_UNITS-1:0] unit_go,
  output logic [UIDX_W-1:0]    cur_unit,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic [UIDX_W-1:0]    err_unit
);

  localparam int DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam int DLY_T = (START_DELAY > 0) ? START_DELAY - 1 : 0;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  tu_seq_state_e        state_reg, state_next;
  tu_err_e              err_code_reg;
  logic [NUM_UNITS-1:0] go_reg;
  logic [UIDX_W-1:0]    cur_reg, cur_next, err_unit_reg;
  logic [NUM_UNITS-1:0] cur_hot, next_hot, later_mask;
  logic                 cur_pass, order_err, last_unit, advance;
  logic                 dly_tc, to_tc;

  // Per-unit decode of the current/next index and of units beyond the current one.
  for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
    assign cur_hot[gi]    = (cur_reg == UIDX_W'(gi));
    assign next_hot[gi]   = (cur_next == UIDX_W'(gi));
    assign later_mask[gi] = (UIDX_W'(gi) > cur_reg);
  end

  assign cur_pass  = |(unit_pass & cur_hot);
  assign order_err = |(unit_pass & later_mask);
  assign last_unit = (cur_reg == UIDX_W'(NUM_UNITS - 1));
  assign advance   = (state_reg == RUN) && cur_pass && !order_err && !last_unit;
  assign cur_next  = advance ? cur_reg + UIDX_W'(1) : cur_reg;

  tu_seq_timer #(.WIDTH(DLY_W), .TERMINAL(DLY_T)) u_dly_timer (
    .clock  (clock),
    .rst_n  (rst_n),
    .load   (state_reg == IDLE),
    .enable (state_reg == DELAY),
    .tc     (dly_tc)
  );

  tu_seq_timer #(.WIDTH(TO_W), .TERMINAL(TIMEOUT_CYCLES - 1)) u_to_timer (
    .clock  (clock),
    .rst_n  (rst_n),
    .load   ((state_reg != RUN) || advance),
    .enable (state_reg == RUN),
    .tc     (to_tc)
  );

  // Out-of-order beats a valid pass; a valid pass beats the timeout.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (start) state_next = (START_DELAY == 0) ? RUN : DELAY;
      DELAY: if (dly_tc) state_next = RUN;
      RUN: begin
        if (order_err || (!cur_pass && to_tc)) state_next = ERR;
        else if (cur_pass && last_unit)        state_next = DONE;
      end
      DONE, ERR: if (clear) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      go_reg       <= '0;
      cur_reg      <= '0;
      err_code_reg <= ERR_NONE;
      err_unit_reg <= '0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == DONE || state_reg == ERR) && clear) begin
        go_reg       <= '0;
        cur_reg      <= '0;
        err_code_reg <= ERR_NONE;
        err_unit_reg <= '0;
      end else if (state_reg == RUN) begin
        cur_reg <= cur_next;
        // Go bits only rise on edges that stay in RUN, so a terminating edge freezes them.
        if (state_next == RUN) go_reg <= go_reg | cur_hot | next_hot;
        if (state_next == ERR) begin
          err_unit_reg <= cur_reg;
          if (order_err) err_code_reg <= ERR_ORDER;
          else           err_code_reg <= ERR_TIMEOUT;
        end
      end
    end
  end

  assign unit_go  = go_reg;
  assign cur_unit = cur_reg;
  assign busy     = (state_reg == DELAY) || (state_reg == RUN);
  assign done     = (state_reg == DONE);
  assign err      = (state_reg == ERR);
  assign err_code = err_code_reg;
  assign err_unit = err_unit_reg;

endmodule

// File: tb/tb_tu_pass_sequencer.sv
// Bench for tu_pass_sequencer: event-timeline reference model for a 4-unit
// chain plus a directed check of a single-unit, zero-delay build.
module tb_tu_pass_sequencer;

  localparam int NU  = 4;
  localparam int SD  = 3;
  localparam int TO  = 100;
  localparam int INF = 1 << 30;

  logic          clock = 1'b0;
  logic          rst_n;
  logic          start, clear;
  logic [NU-1:0] unit_pass, unit_go;
  logic [1:0]    cur_unit, err_code, err_unit;
  logic          busy, done, err;

  logic       start1, clear1;
  logic [0:0] pass1, go1, cur1, eunit1;
  logic       busy1, done1, err1;
  logic [1:0] code1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Trial description and its predicted event timeline (absolute edge numbers).
  int d[NU];
  int rog_a, rog_dt, rog_r, rog_t;
  int s_edge, end_e, e_code, e_unit;
  bit e_done;
  int g[NU];
  int obs_g[NU];

  tu_pass_sequencer #(.NUM_UNITS(NU), .START_DELAY(SD), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .rst_n(rst_n), .start(start), .clear(clear),
    .unit_pass(unit_pass), .unit_go(unit_go), .cur_unit(cur_unit),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .err_unit(err_unit)
  );

  tu_pass_sequencer #(.NUM_UNITS(1), .START_DELAY(0), .TIMEOUT_CYCLES(TO)) dut1 (
    .clock(clock), .rst_n(rst_n), .start(start1), .clear(clear1),
    .unit_pass(pass1), .unit_go(go1), .cur_unit(cur1),
    .busy(busy1), .done(done1), .err(err1), .err_code(code1), .err_unit(eunit1)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] outs();
    return {3'b0, unit_go, cur_unit, busy, done, err, err_code, err_unit};
  endfunction

  function automatic logic [15:0] outs1();
    return {8'b0, go1, cur1, busy1, done1, err1, code1, eunit1};
  endfunction

  // Expected outputs just after edge n, derived from the event timeline.
  function automatic logic [15:0] expect_at(input int n);
    logic [NU-1:0] go;
    int c;
    logic b, dn, er;
    logic [1:0] code, un;
    go = '0;
    c  = 0;
    for (int k = 0; k < NU; k++) begin
      if (g[k] < end_e && n >= g[k]) begin
        go[k] = 1'b1;
        if (k > 0) c++;
      end
    end
    b    = (n >= s_edge) && (n < end_e);
    dn   = e_done && (n >= end_e);
    er   = !e_done && (n >= end_e);
    code = (n >= end_e) ? 2'(e_code) : 2'd0;
    un   = (n >= end_e) ? 2'(e_unit) : 2'd0;
    return {3'b0, go, 2'(c), b, dn, er, code, un};
  endfunction

  task automatic build_timeline(input int s);
    int lim, t, cur;
    s_edge = s;
    g[0]   = s + SD + 1;
    for (int k = 1; k < NU; k++) g[k] = INF;
    e_done = 1'b0;
    end_e  = INF;
    e_code = 0;
    e_unit = 0;
    for (int k = 0; k < NU; k++) begin
      // Unit 0's counter starts on RUN entry, one edge before its go rises.
      lim = (k == 0) ? TO - 1 : TO;
      if (d[k] > lim) begin
        end_e  = g[k] + lim;
        e_code = 1;
        e_unit = k;
        break;
      end
      if (k == NU - 1) begin
        end_e  = g[k] + d[k];
        e_done = 1'b1;
      end else begin
        g[k+1] = g[k] + d[k];
      end
    end
    rog_t = -1;
    if (rog_a >= 0 && g[rog_a] < end_e) begin
      t   = g[rog_a] + rog_dt;
      cur = 0;
      for (int k = 1; k < NU; k++) if (g[k] < t) cur++;
      if (t < end_e && rog_r > cur) begin
        rog_t  = t;
        end_e  = t;
        e_done = 1'b0;
        e_code = 2;
        e_unit = cur;
        for (int k = 0; k < NU; k++) if (g[k] >= t) g[k] = INF;
      end
    end
  endtask

  // Each unit raises and holds pass d[k] edges after its go was seen; a rogue unit may fire early.
  task automatic drive_pass(input int m);
    for (int k = 0; k < NU; k++)
      unit_pass[k] = (obs_g[k] != INF) && (m >= obs_g[k] + d[k]);
    if (rog_t >= 0 && m >= rog_t) unit_pass[rog_r] = 1'b1;
  endtask

  task automatic note_go();
    for (int k = 0; k < NU; k++)
      if (unit_go[k] && obs_g[k] == INF) obs_g[k] = cyc;
  endtask

  task automatic run_trial(input string name, input bit relaunch);
    build_timeline(cyc + 1);
    for (int k = 0; k < NU; k++) obs_g[k] = INF;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc <= end_e + 3) begin
      check($sformatf("%s@%0d", name, cyc), outs(), expect_at(cyc));
      note_go();
      drive_pass(cyc + 1);
      tick();
    end
    $display("trial %s: d=%0d,%0d,%0d,%0d end=%0d done=%0d code=%0d unit=%0d",
             name, d[0], d[1], d[2], d[3], end_e, e_done, e_code, e_unit);
    if (relaunch) begin
      start = 1'b1;
      repeat (2) begin
        tick();
        check("start_in_done", outs(), expect_at(cyc));
      end
      clear     = 1'b1;
      unit_pass = '0;
      tick();
      clear = 1'b0;
      check("clear_idle", outs(), 16'h0);
      tick();
      check("relaunch_delay", outs(), 16'h0040);
      start = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("relaunch_reset", outs(), 16'h0);
    end else begin
      clear     = 1'b1;
      unit_pass = '0;
      tick();
      clear = 1'b0;
      check($sformatf("%s_clear", name), outs(), 16'h0);
    end
  endtask

  initial begin
    int mode, budget;
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; unit_pass = '0;
    start1 = 1'b0; clear1 = 1'b0; pass1 = '0;
    rog_a = -1; rog_t = -1; rog_dt = 0; rog_r = 0;
    for (int k = 0; k < NU; k++) begin d[k] = 10; obs_g[k] = INF; end
    tick();
    tick();
    check("reset_main", outs(), 16'h0);
    check("reset_single", outs1(), 16'h0);
    rst_n = 1'b1;

    // Single unit, no delay: go one edge after start, done right after its pass.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("single_run", outs1(), 16'h20);
    tick();
    check("single_go", outs1(), 16'hA0);
    pass1 = 1'b1;
    tick();
    check("single_done", outs1(), 16'h90);
    clear1 = 1'b1;
    pass1  = 1'b0;
    tick();
    clear1 = 1'b0;
    check("single_clear", outs1(), 16'h0);

    d = '{10, 10, 10, 10};   rog_a = -1;
    run_trial("normal", 1'b0);
    d = '{10, 10, 1000, 10}; rog_a = -1;
    run_trial("timeout", 1'b0);
    d = '{10, 10, 10, 10};   rog_a = 1; rog_dt = 3; rog_r = 3;
    run_trial("order", 1'b0);
    d = '{99, 5, 5, 5};      rog_a = -1;
    run_trial("simul", 1'b0);
    d = '{100, 5, 5, 5};     rog_a = -1;
    run_trial("to_unit0", 1'b0);
    d = '{4, 6, 2, 3};       rog_a = -1;
    run_trial("relaunch", 1'b1);

    for (int t = 0; t < 12; t++) begin
      mode = int'($urandom_range(0, 2));
      for (int k = 0; k < NU; k++) d[k] = int'($urandom_range(1, 25));
      rog_a = -1;
      if (mode == 1) d[$urandom_range(0, NU-1)] = int'($urandom_range(96, 104));
      if (mode == 2) begin
        rog_a  = int'($urandom_range(0, NU-2));
        rog_dt = int'($urandom_range(1, d[rog_a]));
        rog_r  = int'($urandom_range(rog_a + 1, NU-1));
      end
      run_trial($sformatf("rand%0d", t), 1'b0);
    end

    // Asynchronous reset while unit 2 is current.
    d = '{10, 10, 10, 10}; rog_a = -1; rog_t = -1;
    for (int k = 0; k < NU; k++) obs_g[k] = INF;
    start = 1'b1;
    tick();
    start  = 1'b0;
    budget = 0;
    while (cur_unit != 2'd2 && budget < 200) begin
      note_go();
      drive_pass(cyc + 1);
      tick();
      budget++;
    end
    check("reach_unit2", 16'(cur_unit), 16'd2);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", {11'b0, unit_go, busy}, 16'h0);
    unit_pass = '0;
    tick();
    rst_n = 1'b1;
    repeat (5) begin
      tick();
      check("idle_after_reset", outs(), 16'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
